// File: rtl/jstk2_spi_master_pkg.sv
// Shared types and constants for the PmodJSTK2 SPI master and its byte shifter.
package jstk2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP,
    COOL
  } state_t;

  // Position of each field within a received frame, counted in bytes
  localparam int X_LO = 0;
  localparam int X_HI = 1;
  localparam int Y_LO = 2;
  localparam int Y_HI = 3;
  localparam int BTN  = 4;

  localparam int BTN_STICK   = 0;
  localparam int BTN_TRIGGER = 1;

  localparam logic [7:0] LED_CMD = 8'h84;

  typedef struct packed {
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic [1:0] buttons;
  } jstk_pos_t;

endpackage

// File: rtl/jstk2_spi_master_byte_shifter.sv
// One SPI mode-0 byte: MOSI changes at the start of each low phase, MISO is sampled
// in the last cycle of each high phase. byte_done is combinational so the caller can act on the final edge.
module spi_byte_shifter #(
  parameter int SCLK_HALF = 750
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] din,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       byte_done,
  output logic [7:0] rx_byte
);

  localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_HALF - 1);

  logic          active;
  logic [HW-1:0] hcnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_sh;
  logic [6:0]    rx_sh;
  logic          half_end;

  assign half_end  = active && (hcnt == HALF_LAST);
  assign byte_done = half_end && sclk && (bit_cnt == 3'd7);
  assign rx_byte   = {rx_sh, miso};

  // tx_sh holds the bits still to be sent, next one in bit 7
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= 1'b0;
      hcnt    <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else if (load) begin
      active  <= 1'b1;
      hcnt    <= '0;
      bit_cnt <= '0;
      tx_sh   <= {din[6:0], 1'b0};
      mosi    <= din[7];
      sclk    <= 1'b0;
    end else if (active) begin
      if (!half_end) begin
        hcnt <= hcnt + HW'(1);
      end else begin
        hcnt <= '0;
        if (!sclk) begin
          sclk <= 1'b1;
        end else begin
          sclk  <= 1'b0;
          rx_sh <= rx_byte[6:0];
          if (bit_cnt == 3'd7) begin
            active <= 1'b0;
            mosi   <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            mosi    <= tx_sh[7];
            tx_sh   <= {tx_sh[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: rtl/jstk2_spi_master.sv
// PmodJSTK2 SPI master: sequences SS, setup/byte/frame gaps and decodes joystick frames.
// Optional macro JSTK2_AUTO_POLL_EN adds a free-running poll timer that requests frames.
module jstk2_spi_master #(
  parameter int SCLK_HALF     = 750,
  parameter int NBYTES        = 5,
  parameter int SS_SETUP_CYC  = 1500,
  parameter int BYTE_GAP_CYC  = 1000,
  parameter int FRAME_GAP_CYC = 2500,
  parameter int POLL_CYC      = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [8*NBYTES-1:0] tx_data,
  input  logic                MISO,
  output logic                SS,
  output logic                SCLK,
  output logic                MOSI,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] rx_data,
  output logic [9:0]          x_pos,
  output logic [9:0]          y_pos,
  output logic [1:0]          buttons
);

  import jstk2_pkg::*;

  if (NBYTES < 5) begin : g_chk_nbytes
    $error("jstk2_spi_master: NBYTES must be at least 5");
  end
  if (SCLK_HALF < 4) begin : g_chk_half
    $error("jstk2_spi_master: SCLK_HALF must be at least 4");
  end
  if (SS_SETUP_CYC < 1 || BYTE_GAP_CYC < 1 || FRAME_GAP_CYC < 1 || POLL_CYC < 1) begin : g_chk_cyc
    $error("jstk2_spi_master: cycle counts must be at least 1");
  end

  localparam int IDX_W = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [31:0] SETUP_LAST = 32'(SS_SETUP_CYC - 1);
  localparam logic [31:0] GAP_LAST   = 32'(BYTE_GAP_CYC - 1);
  localparam logic [31:0] COOL_LAST  = 32'(FRAME_GAP_CYC - 1);

  state_t              state;
  logic [31:0]         cnt;
  logic [IDX_W-1:0]    byte_idx;
  logic [8*NBYTES-1:0] tx_buf;
  logic [8*NBYTES-1:0] rx_buf;
  logic [8*NBYTES-1:0] rx_next;
  logic                miso_meta;
  logic                miso_sync;
  logic                req;
  logic                load;
  logic [7:0]          din;
  logic                byte_done;
  logic [7:0]          rx_byte;
  jstk_pos_t           pos_next;

`ifdef JSTK2_AUTO_POLL_EN
  localparam logic [31:0] POLL_LAST = 32'(POLL_CYC - 1);
  logic [31:0] poll_cnt;
  logic        poll_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poll_cnt <= '0;
    end else if (poll_cnt == POLL_LAST) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + 32'd1;
    end
  end

  assign poll_tick = (poll_cnt == POLL_LAST);
  assign req       = start | poll_tick;
`else
  assign req = start;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
    end else begin
      miso_meta <= MISO;
      miso_sync <= miso_meta;
    end
  end

  assign load = ((state == SETUP) && (cnt == SETUP_LAST)) ||
                ((state == GAP) && (cnt == GAP_LAST));
  assign din  = tx_buf[{byte_idx, 3'b000} +: 8];

  // Frame image including the byte finishing this cycle, so the last byte lands with done
  always_comb begin
    rx_next = rx_buf;
    rx_next[{byte_idx, 3'b000} +: 8] = rx_byte;
  end

  assign pos_next.x_pos   = {rx_next[8*X_HI +: 2], rx_next[8*X_LO +: 8]};
  assign pos_next.y_pos   = {rx_next[8*Y_HI +: 2], rx_next[8*Y_LO +: 8]};
  assign pos_next.buttons = {rx_next[8*BTN + BTN_TRIGGER], rx_next[8*BTN + BTN_STICK]};

  spi_byte_shifter #(
    .SCLK_HALF(SCLK_HALF)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .din      (din),
    .miso     (miso_sync),
    .sclk     (SCLK),
    .mosi     (MOSI),
    .byte_done(byte_done),
    .rx_byte  (rx_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      byte_idx <= '0;
      SS       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_buf   <= '0;
      rx_buf   <= '0;
      rx_data  <= '0;
      x_pos    <= '0;
      y_pos    <= '0;
      buttons  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            tx_buf   <= tx_data;
            SS       <= 1'b0;
            busy     <= 1'b1;
            cnt      <= '0;
            byte_idx <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        SHIFT: begin
          if (byte_done) begin
            rx_buf <= rx_next;
            cnt    <= '0;
            if (byte_idx == LAST_IDX) begin
              SS      <= 1'b1;
              done    <= 1'b1;
              rx_data <= rx_next;
              x_pos   <= pos_next.x_pos;
              y_pos   <= pos_next.y_pos;
              buttons <= pos_next.buttons;
              state   <= COOL;
            end else begin
              byte_idx <= byte_idx + IDX_W'(1);
              state    <= GAP;
            end
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        COOL: begin
          if (cnt == COOL_LAST) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
